acc_share_ctrl: RTL and testbench
=================================

Name: acc_share_ctrl

Overview:
- Controller that owns and sequences a shared 32-bit state register `out` for the loop/formal test designs.
- Arbitrates between two requesters. Each requester issues a command: LOAD, ADD, RUN (multi-cycle increment loop) or CLEAR.
- Executes one command at a time through a small FSM and signals completion with a one-cycle done pulse tagged with the requester id.

Parameters:
- WIDTH, 32, width of `out` and of the request data.
- RESET_VAL, 32'h0800_0007, value loaded into `out` on reset.
- RUN_W, 8, width of the RUN iteration count, taken from data[RUN_W-1:0].

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_op  input  2  opcode: 00 LOAD, 01 ADD, 10 RUN, 11 CLEAR.
- req0_data  input  WIDTH  operand, or iteration count for RUN.
- req0_ready  output  1  requester 0 is granted this cycle.
- req1_valid, req1_op, req1_data, req1_ready: same as requester 0, for requester 1.
- out  output  WIDTH  shared state register (registered).
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  requester whose command completed; valid when done=1.

Behaviour:
- Reset (RST=1 at an edge):
  - out=RESET_VAL, state=IDLE, last_grant=1 (requester 0 wins the first tie), run count=0.
  - done=0, done_id=0, busy=0.
  - Reset mid-operation aborts the command with no done pulse; out returns to RESET_VAL.
- Grant, combinational, in IDLE only:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Both ready signals are 0 outside IDLE.
- Accept:
  - Occurs at an edge where reqN_valid && reqN_ready.
  - Latches op, data and id; updates last_grant to N.
  - Next state: RUN for op 10 (count loaded from data[RUN_W-1:0]); EXEC otherwise.
  - Requester must hold valid/op/data stable until ready. Dropping valid before ready is legal; nothing is accepted.
- EXEC, one cycle:
  - LOAD: out<=data.
  - ADD: out<=out+data, modulo 2^WIDTH, carry discarded.
  - CLEAR: out<=0.
  - Next state: DONE.
- RUN:
  - count!=0: out<=out+1 (wraps at all-ones to 0), count<=count-1, stay in RUN.
  - count==0: go to DONE with no increment. RUN with count 0 therefore leaves out unchanged.
- DONE, one cycle:
  - done=1, done_id=latched id.
  - Next state: IDLE.
  - done is registered-state decoded and is 0 in every other state.
- Latency, with accept at edge k:
  - LOAD/ADD/CLEAR: out updated at edge k+1, done high in the cycle after k+1, IDLE after edge k+2.
  - RUN N: N increments at edges k+1..k+N, state enters DONE at edge k+N+1, IDLE after edge k+N+2.
  - Minimum command spacing: 3 cycles; RUN N takes N+3.
- busy = (state!=IDLE), decoded from registered state.
- Requests arriving while busy are held off (ready=0) and are not queued.
- Data bits above RUN_W are ignored for RUN.
- Opcode set is complete; no illegal opcodes.
- FSM encoding: 2 bits. Unreachable encodings recover to IDLE at the next edge.

Test Plan:
- Reset → out=0x08000007, busy=0, done=0, both ready=0 with no valid. Hold with no requests for 4 cycles → out unchanged.
- req0 LOAD 0xFFFFFFFE, then req0 ADD 0x3 → out=0xFFFFFFFE one edge after the first accept, then out=0x00000001 (wrap). Each command gives one done pulse with done_id=0.
- req0 and req1 both valid with LOAD values 0x11 and 0x22, held continuously → grant order req0, req1, req0. After each done, out alternates 0x11, 0x22, 0x11. Ready is never high for both in the same cycle.
- req1 RUN data=0x105 (count 5) from out=0x08000007 → out steps to 0x0800000C over 5 consecutive edges, done at cycle k+6, done_id=1, busy high for 7 cycles. RUN with data=0x100 (count 0) → out unchanged, done after 2 cycles.
- Start RUN count 200, assert RST for one edge at iteration 50 → out=0x08000007, state IDLE, no done pulse; a LOAD issued afterwards is accepted normally.
- req0 valid raised then dropped during busy → no accept, no done. CLEAR → out=0 and done.

Source files
------------

// File: rtl/acc_share_ctrl.sv
// Shared state-register controller: arbitrates two requesters and executes one
// LOAD/ADD/RUN/CLEAR command at a time, ending each with a tagged done pulse.
module acc_share_ctrl #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h0800_0007),
   parameter int unsigned      RUN_W     = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic             done_id
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StRun  = 2'b10,
      StDone = 2'b11
   } state_e;

   localparam logic [1:0] OpLoad  = 2'b00;
   localparam logic [1:0] OpAdd   = 2'b01;
   localparam logic [1:0] OpRun   = 2'b10;
   localparam logic [1:0] OpClear = 2'b11;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [1:0]         op_q, op_d;
   logic               id_q, id_d;
   logic               last_grant_q, last_grant_d;
   logic [RUN_W-1:0]   count_q, count_d;

   logic               idle;
   logic               grant1;
   logic               accept;
   logic [1:0]         sel_op;
   logic [WIDTH-1:0]   sel_data;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      idle       = (state_q == StIdle);
      grant1     = req1_valid && (!req0_valid || !last_grant_q);
      req1_ready = idle && grant1;
      req0_ready = idle && req0_valid && !grant1;
      accept     = req0_ready || req1_ready;
      sel_op     = grant1 ? req1_op : req0_op;
      sel_data   = grant1 ? req1_data : req0_data;
   end

   always_comb begin
      state_d      = state_q;
      out_d        = out_q;
      data_d       = data_q;
      op_d         = op_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      count_d      = count_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               op_d         = sel_op;
               data_d       = sel_data;
               id_d         = grant1;
               last_grant_d = grant1;
               if (sel_op == OpRun) begin
                  count_d = sel_data[RUN_W-1:0];
                  state_d = StRun;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            case (op_q)
               OpLoad:  out_d = data_q;
               OpAdd:   out_d = out_q + data_q;
               OpClear: out_d = '0;
               default: out_d = out_q;
            endcase
            state_d = StDone;
         end
         StRun: begin
            if (count_q != '0) begin
               out_d   = out_q + WIDTH'(1);
               count_d = count_q - RUN_W'(1);
            end else begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         out_q        <= RESET_VAL;
         data_q       <= '0;
         op_q         <= OpLoad;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         data_q       <= data_d;
         op_q         <= op_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         count_q      <= count_d;
      end
   end

   assign out     = out_q;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign done_id = id_q;

endmodule

// File: tb/tb_acc_share_ctrl.sv
// Directed self-checking bench for acc_share_ctrl: arbitration, command
// latencies, RUN looping, reset abort and hold-off while busy.
module tb_acc_share_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req0_valid, req1_valid;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic [31:0] out;
   logic        busy, done, done_id;

   int n_cmp = 0;
   int n_err = 0;

   acc_share_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .req0_valid (req0_valid),
      .req0_op    (req0_op),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_op    (req1_op),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .out        (out),
      .busy       (busy),
      .done       (done),
      .done_id    (done_id)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   int busy_cycles;

   initial begin
      RST = 1'b1;
      req0_valid = 0; req0_op = 0; req0_data = 0;
      req1_valid = 0; req1_op = 0; req1_data = 0;
      tick();
      tick();
      RST = 1'b0;
      chk("rst_out", out, 32'h0800_0007);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_done_id", {31'd0, done_id}, 0);
      chk("rst_rdy0", {31'd0, req0_ready}, 0);
      chk("rst_rdy1", {31'd0, req1_ready}, 0);
      repeat (4) tick();
      chk("idle_hold_out", out, 32'h0800_0007);
      chk("idle_hold_done", {31'd0, done}, 0);

      // LOAD then ADD with wraparound
      req0_valid = 1; req0_op = 2'b00; req0_data = 32'hFFFF_FFFE;
      #1 chk("load_rdy0", {31'd0, req0_ready}, 1);
      tick();
      req0_valid = 0;
      chk("load_busy", {31'd0, busy}, 1);
      chk("load_done_early", {31'd0, done}, 0);
      tick();
      chk("load_out", out, 32'hFFFF_FFFE);
      chk("load_done", {31'd0, done}, 1);
      chk("load_done_id", {31'd0, done_id}, 0);
      tick();
      chk("load_done_clr", {31'd0, done}, 0);
      chk("load_idle", {31'd0, busy}, 0);

      req0_valid = 1; req0_op = 2'b01; req0_data = 32'h3;
      #1 chk("add_rdy0", {31'd0, req0_ready}, 1);
      tick();
      req0_valid = 0;
      tick();
      chk("add_out_wrap", out, 32'h0000_0001);
      chk("add_done", {31'd0, done}, 1);
      chk("add_done_id", {31'd0, done_id}, 0);
      tick();
      chk("add_done_clr", {31'd0, done}, 0);

      // Round-robin with both held; fresh reset so req0 wins first
      do_reset();
      req0_valid = 1; req0_op = 2'b00; req0_data = 32'h11;
      req1_valid = 1; req1_op = 2'b00; req1_data = 32'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rr_rdy0", {31'd0, req0_ready}, (i == 1) ? 0 : 1);
         chk("rr_rdy1", {31'd0, req1_ready}, (i == 1) ? 1 : 0);
         chk("rr_not_both", {31'd0, req0_ready & req1_ready}, 0);
         tick();
         chk("rr_busy_rdy", {30'd0, req0_ready, req1_ready}, 0);
         tick();
         chk("rr_out", out, (i == 1) ? 32'h22 : 32'h11);
         chk("rr_done", {31'd0, done}, 1);
         chk("rr_done_id", {31'd0, done_id}, (i == 1) ? 1 : 0);
         chk("rr_done_rdy", {30'd0, req0_ready, req1_ready}, 0);
         tick();
         if (i == 2) begin
            req0_valid = 0;
            req1_valid = 0;
         end
      end

      // RUN count 5 from the reset value
      do_reset();
      req1_valid = 1; req1_op = 2'b10; req1_data = 32'h105;
      #1 chk("run_rdy1", {31'd0, req1_ready}, 1);
      tick();
      req1_valid = 0;
      busy_cycles = 0;
      if (busy) busy_cycles++;
      chk("run_out_k", out, 32'h0800_0007);
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (busy) busy_cycles++;
         chk("run_step", out, 32'h0800_0007 + 32'(i));
         chk("run_no_done", {31'd0, done}, 0);
      end
      tick();
      if (busy) busy_cycles++;
      chk("run_done", {31'd0, done}, 1);
      chk("run_done_id", {31'd0, done_id}, 1);
      chk("run_final", out, 32'h0800_000C);
      tick();
      if (busy) busy_cycles++;
      chk("run_busy_cycles", 32'(busy_cycles), 7);
      chk("run_idle_done", {31'd0, done}, 0);

      // RUN with count 0 (upper data bits ignored)
      req1_valid = 1; req1_op = 2'b10; req1_data = 32'h100;
      tick();
      req1_valid = 0;
      chk("run0_busy", {31'd0, busy}, 1);
      chk("run0_no_done", {31'd0, done}, 0);
      tick();
      chk("run0_done", {31'd0, done}, 1);
      chk("run0_out", out, 32'h0800_000C);
      tick();
      chk("run0_idle", {31'd0, busy}, 0);

      // Reset aborts a long RUN
      req0_valid = 1; req0_op = 2'b10; req0_data = 32'hC8;
      tick();
      req0_valid = 0;
      repeat (50) tick();
      chk("abort_pre_out", out, 32'h0800_003E);
      chk("abort_pre_busy", {31'd0, busy}, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("abort_out", out, 32'h0800_0007);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_done", {31'd0, done}, 0);
      tick();
      tick();
      chk("abort_no_done", {31'd0, done}, 0);
      req1_valid = 1; req1_op = 2'b00; req1_data = 32'h5A5A_5A5A;
      #1 chk("post_abort_rdy1", {31'd0, req1_ready}, 1);
      tick();
      req1_valid = 0;
      tick();
      chk("post_abort_out", out, 32'h5A5A_5A5A);
      chk("post_abort_done_id", {31'd0, done_id}, 1);
      tick();

      // Request raised then dropped while busy is never accepted
      req1_valid = 1; req1_op = 2'b00; req1_data = 32'h33;
      tick();
      req1_valid = 0;
      req0_valid = 1; req0_op = 2'b01; req0_data = 32'h1;
      #1 chk("hold_rdy0", {31'd0, req0_ready}, 0);
      tick();
      req0_valid = 0;
      chk("hold_done", {31'd0, done}, 1);
      chk("hold_done_id", {31'd0, done_id}, 1);
      tick();
      chk("hold_idle", {31'd0, busy}, 0);
      tick();
      tick();
      chk("hold_out", out, 32'h33);
      chk("hold_no_done", {31'd0, done}, 0);
      chk("hold_no_busy", {31'd0, busy}, 0);

      // CLEAR
      req0_valid = 1; req0_op = 2'b11; req0_data = 32'hDEAD_BEEF;
      #1 chk("clr_rdy0", {31'd0, req0_ready}, 1);
      tick();
      req0_valid = 0;
      tick();
      chk("clr_out", out, 32'h0);
      chk("clr_done", {31'd0, done}, 1);
      chk("clr_done_id", {31'd0, done_id}, 0);
      tick();
      chk("clr_idle", {31'd0, busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
